// File: rtl/stepper_pulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stepper_pulse_gen                                          |
// | Description : Stepper motion core. Turns a latched motion command        |
// |               (step count, period, direction, enable) into a STEP/DIR    |
// |               pulse train and tracks absolute position.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   ACLK          in   system clock, rising edge                           |
// |   ARESETN       in   asynchronous active-low reset                       |
// |   enable        in   motion enable; dropping it stops a running command  |
// |   start         in   one-cycle command strobe                            |
// |   abort         in   one-cycle abort strobe                              |
// |   dir           in   1 = forward (+1), 0 = reverse (-1)                  |
// |   step_count    in   number of steps to issue                            |
// |   period        in   STEP rising-to-rising period in ACLK cycles         |
// |   position_clr  in   zero the position counter                           |
// |   step_out      out  STEP to driver (registered)                         |
// |   dir_out       out  DIR to driver (registered)                          |
// |   busy          out  command in progress                                 |
// |   done          out  one-cycle completion pulse                          |
// |   aborted       out  sticky: last command ended by abort / enable drop   |
// |   steps_left    out  steps not yet issued                                |
// |   position      out  signed two's-complement absolute position           |
// +--------------------------------------------------------------------------+
module stepper_pulse_gen #(
    parameter int CNT_WIDTH         = 32,
    parameter int PULSE_HIGH_CYCLES = 4,
    parameter int DIR_SETUP_CYCLES  = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 dir,
    input  logic [CNT_WIDTH-1:0] step_count,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic                 position_clr,
    output logic                 step_out,
    output logic                 dir_out,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_WIDTH-1:0] steps_left,
    output logic [CNT_WIDTH-1:0] position
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_DIR_SETUP  = 3'd1;
    localparam logic [2:0] S_PULSE_HIGH = 3'd2;
    localparam logic [2:0] S_PULSE_LOW  = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    localparam logic [CNT_WIDTH-1:0] c_one          = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_high_cycles  = CNT_WIDTH'(PULSE_HIGH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_min_period   = CNT_WIDTH'(PULSE_HIGH_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] c_setup_reload = CNT_WIDTH'(DIR_SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_high_reload  = CNT_WIDTH'(PULSE_HIGH_CYCLES - 1);

    logic [2:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;         // down-counter for the current phase
    logic [CNT_WIDTH-1:0] r_low_reload;  // PULSE_LOW length minus one, latched at start
    logic                 r_stop_pend;   // stop request seen during a STEP high phase
    logic                 r_step_out;
    logic                 r_dir_out;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_aborted;
    logic [CNT_WIDTH-1:0] r_steps_left;
    logic [CNT_WIDTH-1:0] r_position;

    logic [CNT_WIDTH-1:0] w_period_eff;
    logic [CNT_WIDTH-1:0] w_low_reload;
    logic [CNT_WIDTH-1:0] w_step_delta;
    logic                 w_stop;
    logic                 w_issue_step;

    // The period is clamped so that at least one low cycle separates pulses.
    assign w_period_eff = (period < c_min_period) ? c_min_period : period;
    assign w_low_reload = w_period_eff - c_high_cycles - c_one;

    // Abort and loss of enable are handled identically while moving.
    assign w_stop = abort | ~enable;

    // Adding all-ones is a decrement, so position wraps naturally both ways.
    assign w_step_delta = r_dir_out ? c_one : {CNT_WIDTH{1'b1}};

    // A step is issued on the edge that enters PULSE_HIGH; these are the
    // only two transitions into that state.
    assign w_issue_step = ~w_stop && (r_cnt == '0) &&
                          ((r_state == S_DIR_SETUP) ||
                           ((r_state == S_PULSE_LOW) && (r_steps_left != '0)));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_low_reload <= '0;
            r_stop_pend  <= 1'b0;
            r_step_out   <= 1'b0;
            r_dir_out    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_steps_left <= '0;
            r_position   <= '0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // abort is only meaningful here when paired with start,
                    // where it suppresses the motion but still completes.
                    if (start) begin
                        if (enable && !abort && (step_count != '0)) begin
                            r_state      <= S_DIR_SETUP;
                            r_busy       <= 1'b1;
                            r_steps_left <= step_count;
                            r_low_reload <= w_low_reload;
                            r_dir_out    <= dir;
                            r_aborted    <= 1'b0;
                            r_stop_pend  <= 1'b0;
                            r_cnt        <= c_setup_reload;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                S_DIR_SETUP: begin
                    if (w_stop) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_state    <= S_PULSE_HIGH;
                        r_step_out <= 1'b1;
                        r_cnt      <= c_high_reload;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end

                S_PULSE_HIGH: begin
                    // A stop never truncates the pulse; it is remembered and
                    // acted on when the high phase ends.
                    if (r_cnt == '0) begin
                        r_step_out <= 1'b0;
                        if (r_stop_pend || w_stop) begin
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_aborted <= 1'b1;
                        end else begin
                            r_state <= S_PULSE_LOW;
                            r_cnt   <= r_low_reload;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                        if (w_stop) begin
                            r_stop_pend <= 1'b1;
                        end
                    end
                end

                S_PULSE_LOW: begin
                    if (w_stop) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (r_cnt == '0) begin
                        if (r_steps_left == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_PULSE_HIGH;
                            r_step_out <= 1'b1;
                            r_cnt      <= c_high_reload;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_step_out <= 1'b0;
                end
            endcase

            if (w_issue_step) begin
                r_steps_left <= r_steps_left - c_one;
                r_position   <= r_position + w_step_delta;
            end

            // Clearing wins over a same-cycle step; that step is not counted.
            if (position_clr) begin
                r_position <= '0;
            end
        end
    end

    assign step_out   = r_step_out;
    assign dir_out    = r_dir_out;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign steps_left = r_steps_left;
    assign position   = r_position;

endmodule
`default_nettype wire

// File: doc/stepper_pulse_gen.md
Name: stepper_pulse_gen

Overview:
- Motion core directly downstream of the AXI4-Lite stepper controller register file.
- Consumes the latched command registers (step count, period, direction, enable) and produces STEP/DIR pulse trains for an external stepper driver.
- Tracks absolute position.
- Returns busy/done/steps_left/position for read-back through the register file.

Parameters:
- CNT_WIDTH, 32, width of step_count, period, steps_left and position.
- PULSE_HIGH_CYCLES, 4, STEP high time in ACLK cycles (>=1).
- DIR_SETUP_CYCLES, 8, cycles DIR is held stable before the first STEP edge (>=1).

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- enable  in  1  motion enable from control register bit 0.
- start  in  1  one-cycle command strobe.
- abort  in  1  one-cycle abort strobe.
- dir  in  1  commanded direction; 1 = forward (+1), 0 = reverse (-1).
- step_count  in  CNT_WIDTH  number of steps to issue, unsigned.
- period  in  CNT_WIDTH  STEP rising-to-rising period in ACLK cycles, unsigned.
- position_clr  in  1  zero the position counter.
- step_out  out  1  STEP to driver.
- dir_out  out  1  DIR to driver.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  sticky: last command ended by abort or enable drop.
- steps_left  out  CNT_WIDTH  steps not yet issued.
- position  out  CNT_WIDTH  signed two's-complement absolute position.

Behaviour:
- Reset (async assert, sync release): step_out=0, dir_out=0, busy=0, done=0, aborted=0, steps_left=0, position=0, state=IDLE.
- period_eff = max(period, PULSE_HIGH_CYCLES+1). Computed and latched at start; later changes to inputs are ignored until the next command.

States:
- IDLE: start=1 & enable=1 & step_count!=0 at edge T:
  - latch step_count into steps_left, latch period_eff, dir_out<=dir, aborted<=0.
  - Go to DIR_SETUP; busy=1 from T+1.
  - start with step_count==0 or enable==0: no motion; done=1 at T+1, busy stays 0, aborted unchanged.
- DIR_SETUP: exactly DIR_SETUP_CYCLES cycles, then PULSE_HIGH. First STEP rise at T+1+DIR_SETUP_CYCLES.
- PULSE_HIGH: step_out=1 for PULSE_HIGH_CYCLES cycles.
  - On the entry cycle: steps_left-=1 and position+=1 (dir_out=1) or position-=1 (dir_out=0).
- PULSE_LOW: step_out=0 for period_eff-PULSE_HIGH_CYCLES cycles.
  - Then go to DONE if steps_left==0, else PULSE_HIGH.
  - Consecutive STEP rises are exactly period_eff cycles apart.
- DONE: one cycle; done=1, busy=0; then IDLE.
- busy=1 in DIR_SETUP, PULSE_HIGH and PULSE_LOW only.
- step_out and dir_out are registered; they never glitch.

Abort / edge cases:
- abort=1 or enable=0 while busy:
  - In DIR_SETUP or PULSE_LOW: go to DONE next cycle, aborted<=1.
  - In PULSE_HIGH: the pulse completes its full width (never truncated), then DONE with aborted<=1.
  - steps_left keeps the count of unissued steps.
- abort while IDLE: ignored.
- start while busy: ignored, no effect on latched values.
- start and abort in the same cycle while IDLE: abort wins, no motion, done pulses.
- position_clr has priority over a same-cycle step update: position<=0 and that step is not counted. It is legal at any time.
- position wraps modulo 2^CNT_WIDTH in both directions. No saturation.
- dir_out holds its last value in IDLE.
- Reset mid-operation: immediate return to reset values; step_out drops asynchronously.

Test Plan:
- Reset with ARESETN=0 mid-pulse → step_out=0 immediately; all outputs at reset values; position=0.
- Start at T with step_count=3, period=10, dir=1:
  - STEP rises at T+9, T+19, T+29, each high 4 cycles.
  - done=1 at T+39; busy high T+1..T+38.
  - position=3, steps_left=0, aborted=0.
- Start with step_count=2, period=2, dir=0 → period clamped to 5: rises at T+9 and T+14; position=-2 (0xFFFFFFFE).
- Start with count=100, period=20; abort 2 cycles after the 2nd STEP rise:
  - The 2nd pulse stays high the full 4 cycles, then DONE.
  - steps_left=98, position=2, aborted=1, no further STEP.
- Start with step_count=0 → no STEP; done at T+1; busy never asserts. Start again while busy → ignored.
- position=5, then position_clr in the same cycle as a STEP rise → position=0; next step gives 1. Reverse steps from 0 → wraps to 0xFFFFFFFF.
